// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC arbiter slice.
package cordic_pkg;

    localparam int unsigned FLOAT_DATA_WIDTH = 32;
    localparam int unsigned TIMEOUT_DEFAULT  = 64;

    // Quiet NaN returned when a CORDIC operation has to be abandoned
    localparam logic [FLOAT_DATA_WIDTH-1:0] FLOAT_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESPOND = 3'd3,
        ST_RECOVER = 3'd4
    } arb_state_e;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester and CORDIC-side signals of the arbiter; slave is the arbiter, master the environment.
interface cordic_arbiter_if #(
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned FLOAT_DATA_WIDTH = cordic_pkg::FLOAT_DATA_WIDTH
);

    logic [NUM_REQ-1:0]                  req;
    logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0] req_angle;
    logic [NUM_REQ-1:0]                  rsp_valid;
    logic [FLOAT_DATA_WIDTH-1:0]         rsp_result;
    logic                                rsp_error;
    logic                                busy;
    logic                                cor_clk_en;
    logic                                cor_start;
    logic                                cor_rst;
    logic [FLOAT_DATA_WIDTH-1:0]         cor_angle;
    logic [FLOAT_DATA_WIDTH-1:0]         cor_result;
    logic                                cor_done;

    modport slave (
        input  req, req_angle, cor_result, cor_done,
        output rsp_valid, rsp_result, rsp_error, busy,
               cor_clk_en, cor_start, cor_rst, cor_angle
    );

    modport master (
        output req, req_angle, cor_result, cor_done,
        input  rsp_valid, rsp_result, rsp_error, busy,
               cor_clk_en, cor_start, cor_rst, cor_angle
    );

endinterface

// File: rtl/cordic_arbiter_rr.sv
// Combinational round-robin picker: first unmasked request at or after last_grant+1.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   grant_idx_c_o,
    output logic               grant_valid_c_o
);

    logic [NUM_REQ-1:0] eligible_c;
    int unsigned        cand;

    always_comb begin
        grant_idx_c_o   = '0;
        grant_valid_c_o = 1'b0;
        cand            = 0;
        eligible_c      = req_i & ~mask_i;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_grant_i) + k) % NUM_REQ;
            if (!grant_valid_c_o && eligible_c[IDX_W'(cand)]) begin
                grant_valid_c_o = 1'b1;
                grant_idx_c_o   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one CORDIC cosine unit among NUM_REQ requesters, one operation in flight,
// with timeout recovery that resets the CORDIC and answers with a quiet NaN.
module cordic_arbiter #(
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned FLOAT_DATA_WIDTH = cordic_pkg::FLOAT_DATA_WIDTH,
    parameter int unsigned TIMEOUT          = cordic_pkg::TIMEOUT_DEFAULT
) (
    input logic              clk,
    input logic              rst_n,
    cordic_arbiter_if.slave  arb_if
);
    import cordic_pkg::*;

    localparam int unsigned FW    = FLOAT_DATA_WIDTH;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned SEL_W = $clog2(NUM_REQ * FW);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]      cor_angle_q, cor_angle_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [FW-1:0]      rsp_result_q, rsp_result_d;
    logic               rsp_error_q, rsp_error_d;
    logic               busy_q, busy_d;
    logic               cor_start_q, cor_start_d;
    logic               cor_clk_en_q, cor_clk_en_d;
    logic               cor_rst_q, cor_rst_d;

    logic [IDX_W-1:0]   grant_idx_c;
    logic               grant_valid_c;
    logic [SEL_W-1:0]   angle_base_c;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i           (arb_if.req),
        .mask_i          (mask_q),
        .last_grant_i    (last_grant_q),
        .grant_idx_c_o   (grant_idx_c),
        .grant_valid_c_o (grant_valid_c)
    );

    assign angle_base_c = SEL_W'(grant_idx_c) * SEL_W'(FW);

    // Next state plus output decode; outputs follow the state being entered
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        last_grant_d = last_grant_q;
        mask_d       = '0;
        cnt_d        = cnt_q;
        cor_angle_d  = cor_angle_q;
        rsp_result_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid_c) begin
                    idx_d       = grant_idx_c;
                    cor_angle_d = arb_if.req_angle[angle_base_c +: FW];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (arb_if.cor_done) begin
                    rsp_result_d = arb_if.cor_result;
                    state_d      = ST_RESPOND;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_result_d = FW'(FLOAT_QNAN);
                    state_d      = ST_RECOVER;
                end
            end
            ST_RESPOND, ST_RECOVER: begin
                last_grant_d = idx_q;
                mask_d       = NUM_REQ'(1) << idx_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        rsp_valid_d  = ((state_d == ST_RESPOND) || (state_d == ST_RECOVER))
                       ? (NUM_REQ'(1) << idx_q) : '0;
        rsp_error_d  = (state_d == ST_RECOVER);
        busy_d       = (state_d != ST_IDLE);
        cor_start_d  = (state_d == ST_ISSUE);
        cor_rst_d    = (state_d == ST_RECOVER);
        cor_clk_en_d = (state_d != ST_RECOVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            mask_q       <= '0;
            cnt_q        <= '0;
            cor_angle_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            busy_q       <= 1'b0;
            cor_start_q  <= 1'b0;
            cor_clk_en_q <= 1'b0;
            cor_rst_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            last_grant_q <= last_grant_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            cor_angle_q  <= cor_angle_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            busy_q       <= busy_d;
            cor_start_q  <= cor_start_d;
            cor_clk_en_q <= cor_clk_en_d;
            cor_rst_q    <= cor_rst_d;
        end
    end

    assign arb_if.rsp_valid  = rsp_valid_q;
    assign arb_if.rsp_result = rsp_result_q;
    assign arb_if.rsp_error  = rsp_error_q;
    assign arb_if.busy       = busy_q;
    assign arb_if.cor_start  = cor_start_q;
    assign arb_if.cor_clk_en = cor_clk_en_q;
    assign arb_if.cor_rst    = cor_rst_q;
    assign arb_if.cor_angle  = cor_angle_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a small CORDIC behavioural model.
module tb_cordic_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned FW   = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_arbiter_if #(.NUM_REQ(NREQ), .FLOAT_DATA_WIDTH(FW)) bus ();

    cordic_arbiter #(.NUM_REQ(NREQ), .FLOAT_DATA_WIDTH(FW), .TIMEOUT(64)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_delay = 2;   // 0 means the model never finishes
    logic model_pend;
    int   model_ctr;

    // CORDIC model: done rises done_delay edges after start is seen, stays high until next start
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.cor_rst) begin
            model_pend     <= 1'b0;
            model_ctr      <= 0;
            bus.cor_done   <= 1'b0;
            bus.cor_result <= '0;
        end else if (bus.cor_start) begin
            model_pend   <= 1'b1;
            model_ctr    <= 0;
            bus.cor_done <= 1'b0;
        end else if (model_pend) begin
            model_ctr <= model_ctr + 1;
            if (done_delay != 0 && model_ctr + 1 == done_delay) begin
                bus.cor_done   <= 1'b1;
                bus.cor_result <= 32'h3F80_0000 | bus.cor_angle;
                model_pend     <= 1'b0;
            end
        end
    end

    task automatic wait_rsp(input int max_cyc, output int cyc, output logic [NREQ-1:0] v);
        cyc = 0;
        v   = '0;
        while (cyc < max_cyc && v == '0) begin
            @(negedge clk);
            cyc++;
            v = bus.rsp_valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL rst_rsp_valid got %b want 0000", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_result !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_result got %h want 0", bus.rsp_result); end
        n_cmp++; if (bus.rsp_error !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_error got %b want 0", bus.rsp_error); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.cor_start !== 1'b0) begin n_bad++; $display("FAIL rst_cor_start got %b want 0", bus.cor_start); end
        n_cmp++; if (bus.cor_clk_en !== 1'b0) begin n_bad++; $display("FAIL rst_cor_clk_en got %b want 0", bus.cor_clk_en); end
        n_cmp++; if (bus.cor_rst !== 1'b1) begin n_bad++; $display("FAIL rst_cor_rst got %b want 1", bus.cor_rst); end
        n_cmp++; if (bus.cor_angle !== 32'h0) begin n_bad++; $display("FAIL rst_cor_angle got %h want 0", bus.cor_angle); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.cor_rst !== 1'b1) begin n_bad++; $display("FAIL rel_cor_rst got %b want 1", bus.cor_rst); end
        @(negedge clk);
        n_cmp++; if (bus.cor_rst !== 1'b0 || bus.cor_clk_en !== 1'b1) begin n_bad++; $display("FAIL rel_after got rst=%b en=%b want rst=0 en=1", bus.cor_rst, bus.cor_clk_en); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rel_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        int               cyc;
        logic [NREQ-1:0]  v;
        logic [NREQ-1:0]  exp_v [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [FW-1:0]    exp_r [5] = '{32'h3F80_0000, 32'h3F80_0010, 32'h3F80_0020, 32'h3F80_0030, 32'h3F80_0000};
        done_delay = 2;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(40, cyc, v);
            if (i == 4) bus.req = 4'b0000;
            n_cmp++; if (v !== exp_v[i]) begin n_bad++; $display("FAIL rr_order[%0d] got %b want %b", i, v, exp_v[i]); end
            n_cmp++; if (bus.rsp_result !== exp_r[i]) begin n_bad++; $display("FAIL rr_result[%0d] got %h want %h", i, bus.rsp_result, exp_r[i]); end
            @(negedge clk);
            n_cmp++; if (bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL rr_adjacent[%0d] got %b want 0000", i, bus.rsp_valid); end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        int              cyc;
        logic [NREQ-1:0] v;
        done_delay = 2;
        bus.req = 4'b0001;
        @(negedge clk);
        n_cmp++; if (bus.cor_start !== 1'b1) begin n_bad++; $display("FAIL single_start got %b want 1", bus.cor_start); end
        n_cmp++; if (bus.cor_angle !== 32'h0) begin n_bad++; $display("FAIL single_angle got %h want 0", bus.cor_angle); end
        wait_rsp(20, cyc, v);
        bus.req = 4'b0000;
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL single_latency got %0d want 4", cyc); end
        n_cmp++; if (v !== 4'b0001) begin n_bad++; $display("FAIL single_valid got %b want 0001", v); end
        n_cmp++; if (bus.rsp_result !== 32'h3F80_0000) begin n_bad++; $display("FAIL single_result got %h want 3f800000", bus.rsp_result); end
        n_cmp++; if (bus.rsp_error !== 1'b0) begin n_bad++; $display("FAIL single_error got %b want 0", bus.rsp_error); end
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 4'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_after got v=%b busy=%b want 0000/0", bus.rsp_valid, bus.busy); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mask();
        int              cyc;
        logic [NREQ-1:0] v;
        done_delay = 2;
        bus.req = 4'b0100;
        wait_rsp(20, cyc, v);
        n_cmp++; if (v !== 4'b0100) begin n_bad++; $display("FAIL mask_first got %b want 0100", v); end
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mask_idle got busy=%b want 0", bus.busy); end
        @(negedge clk);
        n_cmp++; if (bus.cor_start !== 1'b0) begin n_bad++; $display("FAIL mask_no_dup got start=%b want 0", bus.cor_start); end
        @(negedge clk);
        n_cmp++; if (bus.cor_start !== 1'b1) begin n_bad++; $display("FAIL mask_regrant got start=%b want 1", bus.cor_start); end
        wait_rsp(20, cyc, v);
        bus.req = 4'b0000;
        n_cmp++; if (v !== 4'b0100 || bus.rsp_result !== 32'h3F80_0020) begin n_bad++; $display("FAIL mask_second got %b/%h want 0100/3f800020", v, bus.rsp_result); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int              cyc;
        logic [NREQ-1:0] v;
        done_delay = 0;
        bus.req = 4'b1000;
        @(negedge clk);
        n_cmp++; if (bus.cor_start !== 1'b1) begin n_bad++; $display("FAIL to_start got %b want 1", bus.cor_start); end
        wait_rsp(100, cyc, v);
        bus.req = 4'b0000;
        n_cmp++; if (cyc !== 65) begin n_bad++; $display("FAIL to_latency got %0d want 65", cyc); end
        n_cmp++; if (v !== 4'b1000) begin n_bad++; $display("FAIL to_valid got %b want 1000", v); end
        n_cmp++; if (bus.rsp_result !== 32'h7FC0_0000) begin n_bad++; $display("FAIL to_result got %h want 7fc00000", bus.rsp_result); end
        n_cmp++; if (bus.rsp_error !== 1'b1) begin n_bad++; $display("FAIL to_error got %b want 1", bus.rsp_error); end
        n_cmp++; if (bus.cor_rst !== 1'b1 || bus.cor_clk_en !== 1'b0) begin n_bad++; $display("FAIL to_cor_rst got rst=%b en=%b want 1/0", bus.cor_rst, bus.cor_clk_en); end
        @(negedge clk);
        n_cmp++; if (bus.cor_rst !== 1'b0 || bus.cor_clk_en !== 1'b1) begin n_bad++; $display("FAIL to_after got rst=%b en=%b want 0/1", bus.cor_rst, bus.cor_clk_en); end
        done_delay = 2;
        bus.req = 4'b0010;
        wait_rsp(20, cyc, v);
        bus.req = 4'b0000;
        n_cmp++; if (v !== 4'b0010 || bus.rsp_result !== 32'h3F80_0010 || bus.rsp_error !== 1'b0) begin n_bad++; $display("FAIL to_next got %b/%h/%b want 0010/3f800010/0", v, bus.rsp_result, bus.rsp_error); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tie();
        int              cyc;
        logic [NREQ-1:0] v;
        done_delay = 63;
        bus.req = 4'b0001;
        @(negedge clk);
        n_cmp++; if (bus.cor_start !== 1'b1) begin n_bad++; $display("FAIL tie_start got %b want 1", bus.cor_start); end
        wait_rsp(100, cyc, v);
        bus.req = 4'b0000;
        n_cmp++; if (cyc !== 65 || v !== 4'b0001) begin n_bad++; $display("FAIL tie_valid got %0d/%b want 65/0001", cyc, v); end
        n_cmp++; if (bus.rsp_error !== 1'b0 || bus.rsp_result !== 32'h3F80_0000) begin n_bad++; $display("FAIL tie_result got %b/%h want 0/3f800000", bus.rsp_error, bus.rsp_result); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int              cyc;
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] seen;
        done_delay = 0;
        bus.req = 4'b0100;
        @(negedge clk);
        n_cmp++; if (bus.cor_start !== 1'b1) begin n_bad++; $display("FAIL rmw_start got %b want 1", bus.cor_start); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0) begin n_bad++; $display("FAIL rmw_rst got busy=%b v=%b want 0/0000", bus.busy, bus.rsp_valid); end
        n_cmp++; if (bus.cor_rst !== 1'b1 || bus.cor_clk_en !== 1'b0) begin n_bad++; $display("FAIL rmw_cor got rst=%b en=%b want 1/0", bus.cor_rst, bus.cor_clk_en); end
        n_cmp++; if (bus.cor_angle !== 32'h0) begin n_bad++; $display("FAIL rmw_angle got %h want 0", bus.cor_angle); end
        bus.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        seen = '0;
        repeat (6) begin
            @(negedge clk);
            seen |= bus.rsp_valid;
        end
        n_cmp++; if (seen !== 4'b0) begin n_bad++; $display("FAIL rmw_no_rsp got %b want 0000", seen); end
        done_delay = 2;
        bus.req = 4'b0100;
        @(negedge clk);
        n_cmp++; if (bus.cor_angle !== 32'h20) begin n_bad++; $display("FAIL rmw_regrant_angle got %h want 00000020", bus.cor_angle); end
        wait_rsp(20, cyc, v);
        bus.req = 4'b0000;
        n_cmp++; if (cyc !== 4 || v !== 4'b0100) begin n_bad++; $display("FAIL rmw_next got %0d/%b want 4/0100", cyc, v); end
        n_cmp++; if (bus.rsp_result !== 32'h3F80_0020 || bus.rsp_error !== 1'b0) begin n_bad++; $display("FAIL rmw_next_result got %h/%b want 3f800020/0", bus.rsp_result, bus.rsp_error); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.req       = 4'b0000;
        bus.req_angle = {32'h0000_0030, 32'h0000_0020, 32'h0000_0010, 32'h0000_0000};
        test_reset();
        test_round_robin();
        test_single();
        test_mask();
        test_timeout();
        test_tie();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
